// File: rtl/gray_updown_counter_if.sv
// ============================================================================
// gray_updown_counter_if : control inputs and count outputs of the counter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gray_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             lim;

  modport master (
    output en, up, load, din,
    input  gray, bin, lim
  );

  modport slave (
    input  en, up, load, din,
    output gray, bin, lim
  );
endinterface

`default_nettype wire

// File: rtl/gray_updown_counter.sv
// ============================================================================
// gray_updown_counter : parametrised up/down Gray counter, wrap or saturate
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int SATURATE  = 0,
  parameter int GRAY_LOAD = 1
) (
  input  wire logic              clk,
  input  wire logic              nrst,
  gray_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] gray_q;
  logic             lim_q;
  logic [WIDTH-1:0] b_next;
  logic             lim_next;
  logic [WIDTH-1:0] din_bin;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    if (GRAY_LOAD != 0) begin : g_gray_load
      always_comb begin
        din_bin = ZERO;
        for (int i = 0; i < WIDTH; i++) begin
          din_bin[i] = ^(bus.din >> i);
        end
      end
    end else begin : g_bin_load
      assign din_bin = bus.din;
    end
  endgenerate

  always_comb begin
    b_next   = b;
    lim_next = 1'b0;
    if (bus.load) begin
      b_next = din_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        if (b == ALL_ONES) begin
          b_next   = (SATURATE != 0) ? b : ZERO;
          lim_next = 1'b1;
        end else begin
          b_next = b + ONE;
        end
      end else begin
        if (b == ZERO) begin
          b_next   = (SATURATE != 0) ? ZERO : ALL_ONES;
          lim_next = 1'b1;
        end else begin
          b_next = b - ONE;
        end
      end
    end
  end

  // Gray is encoded from b_next so it moves on the same edge as the binary count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      b      <= ZERO;
      gray_q <= ZERO;
      lim_q  <= 1'b0;
    end else begin
      b      <= b_next;
      gray_q <= b_next ^ (b_next >> 1);
      lim_q  <= lim_next;
    end
  end

  assign bus.bin  = b;
  assign bus.gray = gray_q;
  assign bus.lim  = lim_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
// ============================================================================
// tb_gray_updown_counter : directed and randomized checks of gray_updown_counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gray_updown_counter;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: 4-bit wrap, Gray load; s: 4-bit saturate; r/q: 7-bit random targets
  gray_updown_counter_if #(.WIDTH(4)) a_if ();
  gray_updown_counter_if #(.WIDTH(4)) s_if ();
  gray_updown_counter_if #(.WIDTH(7)) r_if ();
  gray_updown_counter_if #(.WIDTH(7)) q_if ();

  gray_updown_counter #(.WIDTH(4), .SATURATE(0), .GRAY_LOAD(1)) u_a (.clk(clk), .nrst(nrst), .bus(a_if));
  gray_updown_counter #(.WIDTH(4), .SATURATE(1), .GRAY_LOAD(1)) u_s (.clk(clk), .nrst(nrst), .bus(s_if));
  gray_updown_counter #(.WIDTH(7), .SATURATE(0), .GRAY_LOAD(1)) u_r (.clk(clk), .nrst(nrst), .bus(r_if));
  gray_updown_counter #(.WIDTH(7), .SATURATE(1), .GRAY_LOAD(0)) u_q (.clk(clk), .nrst(nrst), .bus(q_if));

  function automatic int b2g(input int v);
    return v ^ (v >> 1);
  endfunction

  // Inverse Gray by exhaustive search over the code space.
  function automatic int g2b_search(input int g, input int w);
    for (int v = 0; v < (1 << w); v++) begin
      if (b2g(v) == g) return v;
    end
    return -1;
  endfunction

  function automatic int popcount(input int v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    a_if.en = 0; a_if.up = 0; a_if.load = 0; a_if.din = '0;
    s_if.en = 0; s_if.up = 0; s_if.load = 0; s_if.din = '0;
    r_if.en = 0; r_if.up = 0; r_if.load = 0; r_if.din = '0;
    q_if.en = 0; q_if.up = 0; q_if.load = 0; q_if.din = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    nrst = 1'b0;
    #1;
    n_cmp++; if (a_if.bin !== 4'd0)  begin n_err++; $display("FAIL reset_a_bin got %h want 0", a_if.bin); end
    n_cmp++; if (a_if.gray !== 4'd0) begin n_err++; $display("FAIL reset_a_gray got %h want 0", a_if.gray); end
    n_cmp++; if (a_if.lim !== 1'b0)  begin n_err++; $display("FAIL reset_a_lim got %b want 0", a_if.lim); end
    n_cmp++; if (s_if.bin !== 4'd0)  begin n_err++; $display("FAIL reset_s_bin got %h want 0", s_if.bin); end
    n_cmp++; if (s_if.gray !== 4'd0) begin n_err++; $display("FAIL reset_s_gray got %h want 0", s_if.gray); end
    n_cmp++; if (r_if.bin !== 7'd0)  begin n_err++; $display("FAIL reset_r_bin got %h want 0", r_if.bin); end
    n_cmp++; if (r_if.gray !== 7'd0) begin n_err++; $display("FAIL reset_r_gray got %h want 0", r_if.gray); end
    n_cmp++; if (q_if.bin !== 7'd0)  begin n_err++; $display("FAIL reset_q_bin got %h want 0", q_if.bin); end
    n_cmp++; if (q_if.lim !== 1'b0)  begin n_err++; $display("FAIL reset_q_lim got %b want 0", q_if.lim); end
    #1;
    nrst = 1'b1;
  endtask

  task automatic test_count_up_wrap();
    logic [3:0] gseq [16];
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    do_reset();
    a_if.en = 1; a_if.up = 1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_cmp++; if (a_if.gray !== gseq[k % 16]) begin n_err++; $display("FAIL up_wrap_gray step %0d got %b want %b", k, a_if.gray, gseq[k % 16]); end
      n_cmp++; if (a_if.bin !== 4'(k % 16)) begin n_err++; $display("FAIL up_wrap_bin step %0d got %0d want %0d", k, a_if.bin, k % 16); end
      n_cmp++; if (a_if.lim !== (k == 16)) begin n_err++; $display("FAIL up_wrap_lim step %0d got %b want %b", k, a_if.lim, k == 16); end
    end
  endtask

  task automatic test_down_from_reset();
    do_reset();
    a_if.en = 1; a_if.up = 0;
    tick();
    n_cmp++; if (a_if.bin !== 4'b1111)  begin n_err++; $display("FAIL down_bin got %b want 1111", a_if.bin); end
    n_cmp++; if (a_if.gray !== 4'b1000) begin n_err++; $display("FAIL down_gray got %b want 1000", a_if.gray); end
    n_cmp++; if (a_if.lim !== 1'b1)     begin n_err++; $display("FAIL down_lim got %b want 1", a_if.lim); end
    a_if.up = 1;
    tick();
    n_cmp++; if (a_if.bin !== 4'b0000)  begin n_err++; $display("FAIL reverse_bin got %b want 0000", a_if.bin); end
    n_cmp++; if (a_if.gray !== 4'b0000) begin n_err++; $display("FAIL reverse_gray got %b want 0000", a_if.gray); end
    n_cmp++; if (a_if.lim !== 1'b1)     begin n_err++; $display("FAIL reverse_lim got %b want 1", a_if.lim); end
  endtask

  task automatic test_saturate();
    do_reset();
    s_if.en = 1; s_if.up = 1;
    for (int k = 0; k < 15; k++) tick();
    n_cmp++; if (s_if.bin !== 4'd15) begin n_err++; $display("FAIL sat_top_bin got %0d want 15", s_if.bin); end
    n_cmp++; if (s_if.lim !== 1'b0)  begin n_err++; $display("FAIL sat_top_lim got %b want 0", s_if.lim); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (s_if.gray !== 4'b1000) begin n_err++; $display("FAIL sat_hold_gray cycle %0d got %b want 1000", k, s_if.gray); end
      n_cmp++; if (s_if.bin !== 4'd15)    begin n_err++; $display("FAIL sat_hold_bin cycle %0d got %0d want 15", k, s_if.bin); end
      n_cmp++; if (s_if.lim !== 1'b1)     begin n_err++; $display("FAIL sat_hold_lim cycle %0d got %b want 1", k, s_if.lim); end
    end
    s_if.up = 0;
    tick();
    n_cmp++; if (s_if.bin !== 4'b1110)  begin n_err++; $display("FAIL sat_down_bin got %b want 1110", s_if.bin); end
    n_cmp++; if (s_if.gray !== 4'b1001) begin n_err++; $display("FAIL sat_down_gray got %b want 1001", s_if.gray); end
    n_cmp++; if (s_if.lim !== 1'b0)     begin n_err++; $display("FAIL sat_down_lim got %b want 0", s_if.lim); end
  endtask

  task automatic test_gray_load();
    do_reset();
    a_if.load = 1; a_if.en = 1; a_if.up = 1; a_if.din = 4'b0110;
    tick();
    n_cmp++; if (a_if.bin !== 4'b0100)  begin n_err++; $display("FAIL load_bin got %b want 0100", a_if.bin); end
    n_cmp++; if (a_if.gray !== 4'b0110) begin n_err++; $display("FAIL load_gray got %b want 0110", a_if.gray); end
    n_cmp++; if (a_if.lim !== 1'b0)     begin n_err++; $display("FAIL load_lim got %b want 0", a_if.lim); end
    a_if.load = 0;
    tick();
    n_cmp++; if (a_if.gray !== 4'b0111) begin n_err++; $display("FAIL load_step_gray got %b want 0111", a_if.gray); end
    n_cmp++; if (a_if.bin !== 4'b0101)  begin n_err++; $display("FAIL load_step_bin got %b want 0101", a_if.bin); end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_if.en = 1; a_if.up = 1;
    for (int k = 0; k < 9; k++) tick();
    n_cmp++; if (a_if.bin !== 4'd9) begin n_err++; $display("FAIL async_pre_bin got %0d want 9", a_if.bin); end
    #1 nrst = 1'b0;
    #1;
    n_cmp++; if (a_if.gray !== 4'd0) begin n_err++; $display("FAIL async_gray got %b want 0000", a_if.gray); end
    n_cmp++; if (a_if.bin !== 4'd0)  begin n_err++; $display("FAIL async_bin got %b want 0000", a_if.bin); end
    n_cmp++; if (a_if.lim !== 1'b0)  begin n_err++; $display("FAIL async_lim got %b want 0", a_if.lim); end
    #1 nrst = 1'b1;
    tick();
    n_cmp++; if (a_if.gray !== 4'b0001) begin n_err++; $display("FAIL async_release_gray got %b want 0001", a_if.gray); end
  endtask

  // Reference: count is an integer in [0, 2^W), stepping by +/-1 with wrap or clamp.
  task automatic model_step(input int b, input bit en, input bit up, input bit load, input int din,
                            input bit sat, input bit gl, input int w,
                            output int nb, output bit nl, output bit counted);
    int top = (1 << w) - 1;
    nb = b; nl = 0; counted = 0;
    if (load) begin
      nb = gl ? g2b_search(din, w) : din;
    end else if (en) begin
      if (up && b == top) begin
        nl = 1; nb = sat ? top : 0; counted = !sat;
      end else if (!up && b == 0) begin
        nl = 1; nb = sat ? 0 : top; counted = !sat;
      end else begin
        nb = up ? b + 1 : b - 1; counted = 1;
      end
    end
  endtask

  task automatic test_random();
    int  rb, qb, nb, rg_prev, qg_prev;
    bit  nl, rl, ql, rc, qc, rdir, qdir, rld, qld;
    do_reset();
    rb = 0; qb = 0; rl = 0; ql = 0;
    rdir = 1; qdir = 1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(31) == 0) rdir = !rdir;
      if ($urandom_range(31) == 0) qdir = !qdir;
      rld = ($urandom_range(15) == 0);
      qld = ($urandom_range(15) == 0);
      r_if.en = ($urandom_range(3) != 0); r_if.up = rdir; r_if.load = rld; r_if.din = 7'($urandom);
      q_if.en = ($urandom_range(3) != 0); q_if.up = qdir; q_if.load = qld; q_if.din = 7'($urandom);
      model_step(rb, r_if.en, r_if.up, rld, int'(r_if.din), 1'b0, 1'b1, 7, nb, nl, rc);
      rb = nb; rl = nl;
      model_step(qb, q_if.en, q_if.up, qld, int'(q_if.din), 1'b1, 1'b0, 7, nb, nl, qc);
      qb = nb; ql = nl;
      rg_prev = int'(r_if.gray);
      qg_prev = int'(q_if.gray);
      tick();
      n_cmp++; if (int'(r_if.bin) !== rb) begin n_err++; $display("FAIL rand_r_bin cyc %0d got %0d want %0d", cyc, r_if.bin, rb); end
      n_cmp++; if (r_if.lim !== rl) begin n_err++; $display("FAIL rand_r_lim cyc %0d got %b want %b", cyc, r_if.lim, rl); end
      n_cmp++; if (int'(r_if.gray) !== b2g(int'(r_if.bin))) begin n_err++; $display("FAIL rand_r_gray cyc %0d got %h want %h", cyc, r_if.gray, b2g(int'(r_if.bin))); end
      if (!rld) begin
        n_cmp++; if (popcount(int'(r_if.gray) ^ rg_prev) != (rc ? 1 : 0)) begin n_err++; $display("FAIL rand_r_hamming cyc %0d got %0d want %0d", cyc, popcount(int'(r_if.gray) ^ rg_prev), rc ? 1 : 0); end
      end
      n_cmp++; if (int'(q_if.bin) !== qb) begin n_err++; $display("FAIL rand_q_bin cyc %0d got %0d want %0d", cyc, q_if.bin, qb); end
      n_cmp++; if (q_if.lim !== ql) begin n_err++; $display("FAIL rand_q_lim cyc %0d got %b want %b", cyc, q_if.lim, ql); end
      n_cmp++; if (int'(q_if.gray) !== b2g(int'(q_if.bin))) begin n_err++; $display("FAIL rand_q_gray cyc %0d got %h want %h", cyc, q_if.gray, b2g(int'(q_if.bin))); end
      if (!qld) begin
        n_cmp++; if (popcount(int'(q_if.gray) ^ qg_prev) != (qc ? 1 : 0)) begin n_err++; $display("FAIL rand_q_hamming cyc %0d got %0d want %0d", cyc, popcount(int'(q_if.gray) ^ qg_prev), qc ? 1 : 0); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    clear_inputs();
    test_reset();
    test_count_up_wrap();
    test_down_from_reset();
    test_saturate();
    test_gray_load();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gray_updown_counter.md
# gray_updown_counter

Parametrised up/down Gray-code counter, successor to the fixed 4-bit Gray counter. Adds configurable width, direction control, count enable, synchronous parallel load, wrap or saturate mode, and a limit pulse. The Gray output is registered from the next-state value. It therefore changes on the same edge as the internal binary state, with no lag cycle and no combinational decode glitches. Intended for cross-domain pointers and position counters.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at the end value.
- GRAY_LOAD, 1: 1 = din is Gray-coded and is converted to binary on load; 0 = din is plain binary.

- clk  input  1  clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- en  input  1  count enable; one step per enabled edge.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; has priority over en.
- din  input  WIDTH  load value, encoded per GRAY_LOAD.
- gray  output  WIDTH  registered Gray code of the current count.
- bin  output  WIDTH  registered binary count.
- lim  output  1  registered one-cycle pulse when a step crossed or hit the range limit.

## Operation
- Internal state is the binary count b. Registers gray, bin and lim are all flops.
- Next-state selection, in priority order: load, then en, then hold.
  - load=1: b_next = GRAY_LOAD ? g2b(din) : din. Here g2b is the prefix-XOR from the MSB down. lim_next = 0.
  - load=0, en=1, up=1: if b is all ones, then b_next = 0 when SATURATE=0, or b_next = b when SATURATE=1; lim_next = 1 in both cases. Otherwise b_next = b+1 and lim_next = 0.
  - load=0, en=1, up=0: if b is 0, then b_next = all ones when SATURATE=0, or b_next = 0 when SATURATE=1; lim_next = 1. Otherwise b_next = b-1 and lim_next = 0.
  - load=0, en=0: b_next = b, lim_next = 0.
- gray_next = b_next ^ (b_next >> 1), computed from b_next, not from b.
- Arithmetic is modulo 2^WIDTH. There is no carry out apart from lim.
- A direction change takes effect on the same edge. The Gray output still moves by exactly one bit.
- Saturate mode at the limit: gray and bin hold, and lim is asserted on every enabled edge that attempts to pass the limit.
- Load of an arbitrary value may change several Gray bits in one step. Only count steps guarantee a single-bit change.

## Timing
- Reset (nrst low, asynchronous): b=0, bin=0, gray=0, lim=0. This applies immediately, regardless of clk.
- Reset release is synchronous in effect: the first edge with nrst high evaluates normally.
- Latency: inputs sampled at edge k appear on gray, bin and lim after edge k. gray and bin always correspond to the same count.
- lim is high for exactly one cycle per limit event. It is low in any cycle after an edge with load=1 or en=0.
- Reset asserted mid-count aborts the count. No partial update is permitted, and lim clears.
- Every enabled non-saturated step changes exactly one bit of gray. This holds across wrap and across direction reversal.

## Test plan
- Reset, then en=1, up=1 for 17 cycles with WIDTH=4 and SATURATE=0. gray must follow 0000,0001,0011,0010,0110,0111,0101,0100,1100,…,1000,0000. lim=1 only in the cycle after the 15→0 step.
- From reset, en=1, up=0 for one cycle. bin must be 1111, gray 1000 and lim=1. A following up=1 step must give bin 0000, gray 0000 and lim=1.
- SATURATE=1: count up to 15, then hold en=1, up=1 for 3 more cycles. gray must stay 1000 and lim must stay 1 for all three cycles. Then up=0 gives bin 1110, gray 1001 and lim=0.
- GRAY_LOAD=1: load din=0110 with en=1 in the same cycle. Result must be bin 0100, gray 0110, lim=0, so load wins over en. Then one up step gives gray 0111 (bin 0101).
- Assert nrst low asynchronously mid-count at bin 9. gray, bin and lim must read 0 before the next clk edge. After release, the first en edge gives gray 0001.
- Random en/up/load for 10k cycles at WIDTH=7. Checks:
  - The scoreboard matches b.
  - gray equals b2g(bin) at all times.
  - The Hamming distance between consecutive gray values is 1 on non-load, non-saturated enabled steps and 0 otherwise.
